// File: rtl/div_sequencer.sv
// div_sequencer
//   Iterative radix-2 restoring divide engine for the Execute stage. Serves
//   UDIV/SDIV, holds F/D/E through DivBusyE while iterating, and presents the
//   quotient/remainder with a one-cycle DivValidE pulse.
//
//   Optional build macro: DIV_EARLY_OUT_EN
//     When defined, an operation with |A| < |B| (B != 0) finishes in one
//     cycle (quotient 0, remainder = dividend). Results are identical either
//     way; only latency changes.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset, returns to IDLE
//   StartE     in   divide request (UDIV/SDIV with condition passed)
//   SignedE    in   1 = SDIV, 0 = UDIV, sampled with StartE
//   SrcAE      in   dividend, sampled with StartE
//   SrcBE      in   divisor, sampled with StartE
//   FlushE     in   aborts any operation in progress (beats StartE)
//   DivBusyE   out  stall request to hazard unit
//   DivValidE  out  one-cycle pulse, result valid
//   DivResultE out  quotient
//   DivRemE    out  remainder, sign follows dividend

module div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic             SignedE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             FlushE,
    output logic             DivBusyE,
    output logic             DivValidE,
    output logic [WIDTH-1:0] DivResultE,
    output logic [WIDTH-1:0] DivRemE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   stepCnt;
    logic               busyReg;

    // Datapath working registers (no reset; only meaningful while iterating)
    logic [WIDTH-1:0]   divisorR;
    logic [WIDTH-1:0]   quoR;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   remR;
    logic               quoNeg;
    logic               remNeg;

    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic               startOk;
    logic               shortcut;
    logic               earlyOut;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;

    // Operand conditioning for the start cycle. 0x80000000 negates to itself,
    // which is the correct unsigned magnitude, so SDIV overflow needs no
    // special handling.
    assign aNeg    = SignedE & SrcAE[WIDTH-1];
    assign bNeg    = SignedE & SrcBE[WIDTH-1];
    assign magA    = aNeg ? -SrcAE : SrcAE;
    assign magB    = bNeg ? -SrcBE : SrcBE;
    assign startOk = (state == IDLE) && StartE && !FlushE;

`ifdef DIV_EARLY_OUT_EN
    assign earlyOut = (SrcBE != '0) && (magA < magB);
`else
    assign earlyOut = 1'b0;
`endif

    // Divide-by-zero and early-out both finish with quotient 0, remainder = A
    assign shortcut = (SrcBE == '0) || earlyOut;

    // One restoring step: shift remainder:dividend left, trial-subtract.
    // The remainder is always below the divisor, so WIDTH+1 bits suffice.
    assign shifted = {remR, quoR[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisorR};

    // The stall must be visible in the request cycle itself, before the FSM
    // has left IDLE, hence the combinational start term.
    assign DivBusyE = busyReg | (startOk & ~reset);

    always_ff @(posedge clk) begin
        if (startOk) begin
            divisorR <= magB;
            quoR     <= magA;
            remR     <= '0;
            quoNeg   <= aNeg ^ bNeg;
            remNeg   <= aNeg;
        end else if (state == CALC) begin
            quoR <= {quoR[WIDTH-2:0], ~diff[WIDTH]};
            remR <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            stepCnt    <= '0;
            busyReg    <= 1'b0;
            DivValidE  <= 1'b0;
            DivResultE <= '0;
            DivRemE    <= '0;
        end else if (FlushE) begin
            state     <= IDLE;
            stepCnt   <= '0;
            busyReg   <= 1'b0;
            DivValidE <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DivValidE <= 1'b0;
                    stepCnt   <= '0;
                    if (StartE) begin
                        if (shortcut) begin
                            DivResultE <= '0;
                            DivRemE    <= SrcAE;
                            DivValidE  <= 1'b1;
                            state      <= DONE;
                        end else begin
                            busyReg <= 1'b1;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (stepCnt == CNT_W'(WIDTH - 1)) begin
                        stepCnt <= '0;
                        state   <= FIX;
                    end else begin
                        stepCnt <= stepCnt + CNT_W'(1);
                    end
                end
                FIX: begin
                    DivResultE <= quoNeg ? -quoR : quoR;
                    DivRemE    <= remNeg ? -remR : remR;
                    busyReg    <= 1'b0;
                    DivValidE  <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    // Same instruction still sits in E, so StartE is ignored
                    DivValidE <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busyReg   <= 1'b0;
                    DivValidE <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         StartE;
    logic         SignedE;
    logic [W-1:0] SrcAE;
    logic [W-1:0] SrcBE;
    logic         FlushE;
    logic         DivBusyE;
    logic         DivValidE;
    logic [W-1:0] DivResultE;
    logic [W-1:0] DivRemE;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
    } exp_t;

    exp_t sbq[$];

    div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .StartE     (StartE),
        .SignedE    (SignedE),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .FlushE     (FlushE),
        .DivBusyE   (DivBusyE),
        .DivValidE  (DivValidE),
        .DivResultE (DivResultE),
        .DivRemE    (DivRemE)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    // Reference: wide signed arithmetic truncates toward zero, remainder
    // takes the dividend's sign, which is the required behaviour.
    function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
        longint sa, sb;
        if (b == '0) begin
            q = '0; r = a; lat = 1;
            return;
        end
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        lat = W + 2;
`ifdef DIV_EARLY_OUT_EN
        begin
            logic [W-1:0] ma, mb;
            ma = (s && a[W-1]) ? -a : a;
            mb = (s && b[W-1]) ? -b : b;
            if (ma < mb) lat = 1;
        end
`endif
    endfunction

    // Called mid-cycle (shortly after a rising edge): this cycle is T.
    task automatic issueOp(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit push, output logic busyNow);
        exp_t e;
        SignedE = s;
        SrcAE   = a;
        SrcBE   = b;
        StartE  = 1'b1;
        #1;
        busyNow = DivBusyE;
        if (push) begin
            model(s, a, b, e.q, e.r, e.lat);
            sbq.push_back(e);
        end
    endtask

    // Steps cycles until DivValidE, recording latency and busy behaviour.
    // With hold set, StartE stays high and SrcAE is scrambled while busy.
    task automatic collect(input bit hold, output int lat, output logic [W-1:0] q,
                           output logic [W-1:0] r, output bit busyOk);
        lat = -1; busyOk = 1'b1; q = 'x; r = 'x;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk); #1;
            if (!hold) StartE = 1'b0;
            else SrcAE = $urandom;
            #1;
            if (DivValidE === 1'b1) begin
                lat = n; q = DivResultE; r = DivRemE;
                if (DivBusyE !== 1'b0) busyOk = 1'b0;
                break;
            end else if (DivBusyE !== 1'b1) begin
                busyOk = 1'b0;
            end
        end
        StartE = 1'b0;
        if (lat >= 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; StartE = 1'b1; SignedE = 1'b0; SrcAE = 32'd5; SrcBE = 32'd1; FlushE = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (DivBusyE !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", DivBusyE); end
        checks++; if (DivValidE !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", DivValidE); end
        checks++; if (DivResultE !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", DivResultE); end
        checks++; if (DivRemE !== '0) begin failures++; $display("FAIL reset_rem got=%h exp=0", DivRemE); end
        StartE = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_udiv();
        logic bz; int lat; logic [W-1:0] q, r; bit bok; exp_t e;
        issueOp(1'b0, 32'd100, 32'd7, 1'b1, bz);
        collect(1'b0, lat, q, r, bok);
        e = sbq.pop_front();
        checks++; if (bz !== 1'b1) begin failures++; $display("FAIL udiv_busyT got=%b exp=1", bz); end
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL udiv_lat got=%0d exp=%0d", lat, e.lat); end
        checks++; if (!bok) begin failures++; $display("FAIL udiv_busy_window got=bad exp=ok"); end
        checks++; if (q !== 32'd14 || q !== e.q) begin failures++; $display("FAIL udiv_q got=%h exp=%h", q, e.q); end
        checks++; if (r !== 32'd2 || r !== e.r) begin failures++; $display("FAIL udiv_r got=%h exp=%h", r, e.r); end
    endtask

    task automatic test_sdiv();
        logic [W-1:0] as [3] = '{32'hFFFFFF9C, 32'd100, 32'h80000000};
        logic [W-1:0] bs [3] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFFF};
        logic [W-1:0] eq [3] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'h80000000};
        logic [W-1:0] er [3] = '{32'hFFFFFFFE, 32'd2, 32'd0};
        logic bz; int lat; logic [W-1:0] q, r; bit bok; exp_t e;
        for (int i = 0; i < 3; i++) begin
            issueOp(1'b1, as[i], bs[i], 1'b1, bz);
            collect(1'b0, lat, q, r, bok);
            e = sbq.pop_front();
            checks++; if (lat !== W + 2) begin failures++; $display("FAIL sdiv%0d_lat got=%0d exp=%0d", i, lat, W + 2); end
            checks++; if (q !== eq[i] || q !== e.q) begin failures++; $display("FAIL sdiv%0d_q got=%h exp=%h", i, q, eq[i]); end
            checks++; if (r !== er[i] || r !== e.r) begin failures++; $display("FAIL sdiv%0d_r got=%h exp=%h", i, r, er[i]); end
            checks++; if (!bok || bz !== 1'b1) begin failures++; $display("FAIL sdiv%0d_busy got=%b/%b exp=1/1", i, bz, bok); end
        end
    endtask

    task automatic test_div_zero();
        logic bz; int lat; logic [W-1:0] q, r; bit bok; exp_t e;
        issueOp(1'b0, 32'h12345678, 32'd0, 1'b1, bz);
        collect(1'b0, lat, q, r, bok);
        e = sbq.pop_front();
        checks++; if (bz !== 1'b1) begin failures++; $display("FAIL dz_busyT got=%b exp=1", bz); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL dz_lat got=%0d exp=1", lat); end
        checks++; if (!bok) begin failures++; $display("FAIL dz_busy_after got=high exp=low"); end
        checks++; if (q !== e.q) begin failures++; $display("FAIL dz_q got=%h exp=%h", q, e.q); end
        checks++; if (r !== 32'h12345678) begin failures++; $display("FAIL dz_r got=%h exp=12345678", r); end
    endtask

    task automatic test_flush();
        logic bz; int lat; logic [W-1:0] q, r; bit bok; exp_t e; bit sawValid;
        sawValid = 1'b0;
        issueOp(1'b0, 32'd1000, 32'd3, 1'b0, bz);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            StartE = 1'b0;
            if (DivValidE === 1'b1) sawValid = 1'b1;
        end
        FlushE = 1'b1;                       // cycle T+10
        @(posedge clk); #1;                  // cycle T+11
        FlushE = 1'b0;
        #1;
        checks++; if (DivBusyE !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", DivBusyE); end
        if (DivValidE === 1'b1) sawValid = 1'b1;
        @(posedge clk); #1;                  // cycle T+12
        if (DivValidE === 1'b1) sawValid = 1'b1;
        checks++; if (sawValid) begin failures++; $display("FAIL flush_novalid got=1 exp=0"); end
        issueOp(1'b0, 32'd9, 32'd3, 1'b1, bz);
        collect(1'b0, lat, q, r, bok);
        e = sbq.pop_front();
        checks++; if (lat !== W + 2) begin failures++; $display("FAIL flush_next_lat got=%0d exp=%0d", lat, W + 2); end
        checks++; if (q !== 32'd3 || r !== e.r) begin failures++; $display("FAIL flush_next_qr got=%h/%h exp=3/%h", q, r, e.r); end
        // Flush beats a same-cycle start
        SrcAE = 32'd50; SrcBE = 32'd5; SignedE = 1'b0; StartE = 1'b1; FlushE = 1'b1;
        #1;
        checks++; if (DivBusyE !== 1'b0) begin failures++; $display("FAIL flush_prio_busy got=%b exp=0", DivBusyE); end
        @(posedge clk); #1;
        StartE = 1'b0; FlushE = 1'b0;
        #1;
        checks++; if (DivBusyE !== 1'b0) begin failures++; $display("FAIL flush_prio_idle got=%b exp=0", DivBusyE); end
    endtask

    task automatic test_reset_mid();
        logic bz;
        issueOp(1'b0, 32'd77, 32'd5, 1'b0, bz);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            StartE = 1'b0;
        end
        reset = 1'b1;                        // cycle T+5, asynchronous
        #1;
        checks++; if (DivBusyE !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", DivBusyE); end
        checks++; if (DivResultE !== '0 || DivRemE !== '0) begin failures++; $display("FAIL rmid_out got=%h/%h exp=0/0", DivResultE, DivRemE); end
        checks++; if (DivValidE !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", DivValidE); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_early_out();
        logic bz; int lat; logic [W-1:0] q, r; bit bok; exp_t e;
        issueOp(1'b0, 32'd5, 32'd9, 1'b1, bz);
        collect(1'b0, lat, q, r, bok);
        e = sbq.pop_front();
`ifdef DIV_EARLY_OUT_EN
        checks++; if (lat !== 1) begin failures++; $display("FAIL early_lat got=%0d exp=1", lat); end
`else
        checks++; if (lat !== W + 2) begin failures++; $display("FAIL early_lat got=%0d exp=%0d", lat, W + 2); end
`endif
        checks++; if (q !== 32'd0 || r !== 32'd5 || q !== e.q) begin failures++; $display("FAIL early_qr got=%h/%h exp=0/5", q, r); end
    endtask

    task automatic test_back_to_back();
        logic bz; int lat; logic [W-1:0] q, r, a, b; bit bok; exp_t e; logic s;
        for (int i = 0; i < 8; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
            if (i == 5) b = 32'hFFFFFFFF;
            issueOp(s, a, b, 1'b1, bz);
            collect(i[0], lat, q, r, bok);
            e = sbq.pop_front();
            checks++;
            if (lat !== e.lat || q !== e.q || r !== e.r || !bok || bz !== 1'b1) begin
                failures++;
                $display("FAIL b2b%0d s=%b a=%h b=%h got q=%h r=%h lat=%0d exp q=%h r=%h lat=%0d busy=%b/%b",
                         i, s, a, b, q, r, lat, e.q, e.r, e.lat, bz, bok);
            end
        end
    endtask

    initial begin
        test_reset();
        test_udiv();
        test_sdiv();
        test_div_zero();
        test_flush();
        test_reset_mid();
        test_early_out();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
